// File: rtl/wb_write_queue.sv
// Writeback write queue: merges MEM and ALU results in order and drains one entry per cycle to the register file.
// Latency: an entry accepted into an empty queue is written one cycle later.
// Backpressure: ready is based on free slots; a pop this cycle frees no slot. Optional macro: WB_ZERO_DROP_EN.
module wb_write_queue #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [ASIZE-1:0] mem_addr,
  input  logic [DSIZE-1:0] mem_data,
  output logic             mem_ready,
  input  logic             alu_valid,
  input  logic [ASIZE-1:0] alu_addr,
  input  logic [DSIZE-1:0] alu_data,
  output logic             alu_ready,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] q_addr1,
  output logic             q_hit1,
  output logic [DSIZE-1:0] q_data1,
  input  logic [ASIZE-1:0] q_addr2,
  output logic             q_hit2,
  output logic [DSIZE-1:0] q_data2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ASIZE-1:0] ent_addr [DEPTH];
  logic [DSIZE-1:0] ent_data [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    alu_slot;
  logic [CW-1:0]    count;
  logic [CW-1:0]    free;
  logic             mem_acc;
  logic             alu_acc;
  logic             mem_push;
  logic             alu_push;
  logic             pop;

  assign free      = CW'(DEPTH) - count;
  assign mem_ready = (free >= CW'(1));
  // MEM is older, so it gets the last free slot ahead of ALU.
  assign alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !mem_valid);

  assign mem_acc = mem_valid && mem_ready;
  assign alu_acc = alu_valid && alu_ready;

`ifdef WB_ZERO_DROP_EN
  assign mem_push = mem_acc && (mem_addr != '0);
  assign alu_push = alu_acc && (alu_addr != '0);
`else
  assign mem_push = mem_acc;
  assign alu_push = alu_acc;
`endif

  assign pop      = (count != '0);
  assign alu_slot = tail + PW'(mem_push);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + PW'(1);
      tail  <= tail + PW'(mem_push) + PW'(alu_push);
      count <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      ent_addr[tail] <= mem_addr;
      ent_data[tail] <= mem_data;
    end
    if (alu_push) begin
      ent_addr[alu_slot] <= alu_addr;
      ent_data[alu_slot] <= alu_data;
    end
  end

  assign wen   = pop;
  assign waddr = pop ? ent_addr[head] : '0;
  assign wdata = pop ? ent_data[head] : '0;

  // Scan oldest to youngest so the last match found is the youngest.
  function automatic logic [DSIZE:0] lookup(input logic [ASIZE-1:0] qa);
    logic [DSIZE:0] r;
    logic [PW-1:0]  idx;
    r = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (ent_addr[idx] == qa)) r = {1'b1, ent_data[idx]};
    end
`ifdef WB_ZERO_DROP_EN
    if (qa == '0) r = '0;
`endif
    return r;
  endfunction

  assign {q_hit1, q_data1} = lookup(q_addr1);
  assign {q_hit2, q_data2} = lookup(q_addr2);

endmodule

// File: tb/tb_wb_write_queue.sv
// Randomized and directed bench for wb_write_queue against a queue-based reference model.
module tb_wb_write_queue;

  localparam int DSIZE = 16;
  localparam int ASIZE = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_valid, alu_valid;
  logic [ASIZE-1:0] mem_addr, alu_addr, q_addr1, q_addr2;
  logic [DSIZE-1:0] mem_data, alu_data;
  logic             mem_ready, alu_ready, wen, q_hit1, q_hit2;
  logic [ASIZE-1:0] waddr;
  logic [DSIZE-1:0] wdata, q_data1, q_data2;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;
  int wr_cnt  = 0;

  typedef struct packed {
    logic [ASIZE-1:0] a;
    logic [DSIZE-1:0] d;
  } ent_t;
  ent_t mq[$];

  wb_write_queue #(.DSIZE(DSIZE), .ASIZE(ASIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .q_addr1(q_addr1), .q_hit1(q_hit1), .q_data1(q_data1),
    .q_addr2(q_addr2), .q_hit2(q_hit2), .q_data2(q_data2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_mem_ready();
    return (DEPTH - mq.size()) >= 1;
  endfunction

  function automatic bit exp_alu_ready();
    int free = DEPTH - mq.size();
    return (free >= 2) || (free == 1 && !mem_valid);
  endfunction

  function automatic bit dropped(input logic [ASIZE-1:0] a);
`ifdef WB_ZERO_DROP_EN
    return a == '0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DSIZE:0] exp_look(input logic [ASIZE-1:0] qa);
    logic [DSIZE:0] r = '0;
    if (!dropped(qa))
      foreach (mq[i]) if (mq[i].a == qa) r = {1'b1, mq[i].d};
    return r;
  endfunction

  // Reference model: plain FIFO of {addr,data}; pop head, then push MEM, then ALU.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else begin
      bit ma, aa;
      ma = mem_valid && exp_mem_ready();
      aa = alu_valid && exp_alu_ready();
      if (mq.size() > 0) void'(mq.pop_front());
      if (ma && !dropped(mem_addr)) mq.push_back('{a: mem_addr, d: mem_data});
      if (aa && !dropped(alu_addr)) mq.push_back('{a: alu_addr, d: alu_data});
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      acc_cnt += int'(mem_valid && mem_ready) + int'(alu_valid && alu_ready);
      wr_cnt  += int'(wen);
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    logic [DSIZE:0] l1, l2;
    l1 = exp_look(q_addr1);
    l2 = exp_look(q_addr2);
    chk("mem_ready", 32'(mem_ready), 32'(exp_mem_ready()));
    chk("alu_ready", 32'(alu_ready), 32'(exp_alu_ready()));
    chk("wen",   32'(wen),   32'(mq.size() != 0));
    chk("waddr", 32'(waddr), (mq.size() != 0) ? 32'(mq[0].a) : 32'd0);
    chk("wdata", 32'(wdata), (mq.size() != 0) ? 32'(mq[0].d) : 32'd0);
    chk("q_hit1",  32'(q_hit1),  32'(l1[DSIZE]));
    chk("q_data1", 32'(q_data1), 32'(l1[DSIZE-1:0]));
    chk("q_hit2",  32'(q_hit2),  32'(l2[DSIZE]));
    chk("q_data2", 32'(q_data2), 32'(l2[DSIZE-1:0]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit mv, input int ma, input int md, input bit av, input int aa, input int ad);
    mem_valid = mv; mem_addr = ASIZE'(ma); mem_data = DSIZE'(md);
    alu_valid = av; alu_addr = ASIZE'(aa); alu_data = DSIZE'(ad);
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0);
    repeat (DEPTH + 2) tick();
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    q_addr1 = '0; q_addr2 = '0;
    #2;
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("rst_hit1", 32'(q_hit1), 32'd0);
    chk("rst_data1", 32'(q_data1), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Single ALU result
    drive(0, 0, 0, 1, 3, 16'h1234);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("single_wen", 32'(wen), 32'd1);
    chk("single_waddr", 32'(waddr), 32'd3);
    chk("single_wdata", 32'(wdata), 32'h1234);
    @(negedge clk);
    chk("single_idle", 32'(wen), 32'd0);
    tick();

    // Simultaneous sources to the same register
    drive(1, 5, 16'hAAAA, 1, 5, 16'hBBBB);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    q_addr1 = 4'd5;
    @(negedge clk);
    chk("simul_wdata0", 32'(wdata), 32'hAAAA);
    chk("simul_hit", 32'(q_hit1), 32'd1);
    chk("simul_young", 32'(q_data1), 32'hBBBB);
    @(negedge clk);
    chk("simul_wdata1", 32'(wdata), 32'hBBBB);
    chk("simul_waddr1", 32'(waddr), 32'd5);
    drain();

    // Credit edge at count=3
    drive(1, 1, 16'h0101, 1, 2, 16'h0202);
    tick();
    drive(1, 3, 16'h0303, 1, 4, 16'h0404);
    tick();
    drive(1, 5, 16'h0505, 1, 6, 16'h0606);
    @(negedge clk);
    chk("credit_cnt", 32'(mq.size()), 32'd3);
    chk("credit_alu_blk", 32'(alu_ready), 32'd0);
    chk("credit_mem_ok", 32'(mem_ready), 32'd1);
    tick();
    drive(1, 7, 16'h0707, 1, 8, 16'h0808);
    @(negedge clk);
    chk("credit_cnt2", 32'(mq.size()), 32'd3);
    chk("credit_alu_blk2", 32'(alu_ready), 32'd0);
    drain();

    // Asynchronous reset mid-cycle with 3 queued entries
    drive(1, 7, 16'h1111, 1, 8, 16'h2222);
    tick();
    drive(1, 9, 16'h3333, 1, 10, 16'h4444);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    q_addr1 = 4'd9;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_wen", 32'(wen), 32'd0);
    chk("arst_mem_ready", 32'(mem_ready), 32'd1);
    chk("arst_alu_ready", 32'(alu_ready), 32'd1);
    chk("arst_hit1", 32'(q_hit1), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("arst_no_stale", 32'(wen), 32'd0);
    tick();

    // Address 0 handling
    drive(0, 0, 0, 1, 0, 16'h00FF);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    q_addr1 = 4'd0;
    @(negedge clk);
`ifdef WB_ZERO_DROP_EN
    chk("zero_wen", 32'(wen), 32'd0);
    chk("zero_hit", 32'(q_hit1), 32'd0);
`else
    chk("zero_wen", 32'(wen), 32'd1);
    chk("zero_waddr", 32'(waddr), 32'd0);
    chk("zero_wdata", 32'(wdata), 32'h00FF);
`endif
    drain();

    // Sustained backpressure: both sources always valid
    acc_cnt = 0; wr_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      drive(1, 1 + (2 * i) % 15, 16'hA000 + i, 1, 1 + (2 * i + 1) % 15, 16'hB000 + i);
      q_addr1 = ASIZE'(1 + (2 * i) % 15);
      if (i == 5) begin
        @(negedge clk);
        chk("bp_alu_blk", 32'(alu_ready), 32'd0);
      end
      tick();
    end
    drain();
    chk("bp_no_loss", 32'(wr_cnt), 32'(acc_cnt));

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom);
      if (mq.size() > 0 && $urandom_range(0, 1) == 1)
        q_addr1 = mq[$urandom_range(0, mq.size() - 1)].a;
      else
        q_addr1 = ASIZE'($urandom_range(0, 15));
      q_addr2 = (mq.size() > 0) ? mq[mq.size() - 1].a : ASIZE'($urandom_range(0, 15));
      rst = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
